frame_sequencer: RTL and testbench

Per-frame scheduler for the game loop. It divides the system clock into fixed-rate frame ticks and samples the active-low push-buttons once per frame. Each frame it sequences the player sprite update, the obstacle update and the LCD render through request/done handshakes. It sits between the board inputs and the sprite/render datapath, and is the sole source of the `update` strobe that drives the player sprite state machine.

---
 rtl/frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_frame_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame tick, key sampling and player/obstacle/render sequencing
// playerUpdate is registered: tick at T -> pending at T+1 -> strobe with state PLAYER at T+2.
module frame_sequencer #(
  parameter int TICK_DIVIDE = 833333,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  keys,
  input  logic        pause,
  input  logic        playerDone,
  input  logic        obstacleDone,
  input  logic        renderDone,
  output logic        playerUpdate,
  output logic        obstacleUpdate,
  output logic        renderReq,
  output logic [3:0]  keysFrame,
  output logic [15:0] frameCount,
  output logic [7:0]  overruns,
  output logic        timeoutFlag,
  output logic        busy
);

  localparam int              TW         = $clog2(TICK_DIVIDE);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIVIDE - 1);
  localparam logic [15:0]     STAGE_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PLAYER, OBSTACLE, RENDER} state_t;

  state_t         state, state_next;
  logic [TW-1:0]  tick_count;
  logic           tick;
  logic [3:0]     key_meta, key_sync;
  logic           tick_pending;
  logic [15:0]    stage_count;
  logic           accept, advance, done_sel, stage_expired;

  assign tick          = (tick_count == TICK_LAST);
  assign stage_expired = (stage_count == STAGE_LAST);
  assign renderReq     = (state == RENDER);
  assign busy          = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_meta <= 4'hF;
      key_sync <= 4'hF;
    end else begin
      key_meta <= keys;
      key_sync <= key_meta;
    end
  end

  // A tick coinciding with acceptance re-arms pending without counting an overrun.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_pending <= 1'b0;
      overruns     <= 8'h00;
    end else if (tick) begin
      tick_pending <= 1'b1;
      if (tick_pending && !accept && overruns != 8'hFF) begin
        overruns <= overruns + 8'h01;
      end
    end else if (accept) begin
      tick_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    done_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (tick_pending && !pause) begin
          accept     = 1'b1;
          state_next = PLAYER;
        end
      end
      PLAYER: begin
        done_sel = playerDone;
        if (playerDone || stage_expired) begin
          advance    = 1'b1;
          state_next = OBSTACLE;
        end
      end
      OBSTACLE: begin
        done_sel = obstacleDone;
        if (obstacleDone || stage_expired) begin
          advance    = 1'b1;
          state_next = RENDER;
        end
      end
      RENDER: begin
        done_sel = renderDone;
        if (renderDone || stage_expired) begin
          advance    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stage_count    <= 16'h0000;
      playerUpdate   <= 1'b0;
      obstacleUpdate <= 1'b0;
      keysFrame      <= 4'hF;
      frameCount     <= 16'h0000;
      timeoutFlag    <= 1'b0;
    end else begin
      if (state_next != state || state == IDLE) begin
        stage_count <= 16'h0000;
      end else begin
        stage_count <= stage_count + 16'h0001;
      end
      playerUpdate   <= accept;
      obstacleUpdate <= advance && (state == PLAYER);
      if (accept) begin
        keysFrame <= key_sync;
      end
      if (advance && state == RENDER) begin
        frameCount <= frameCount + 16'h0001;
      end
      if (advance && !done_sel) begin
        timeoutFlag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer
// Two instances: dut (TIMEOUT=40, responsive dones) and tdut (TIMEOUT=4, dones never asserted).
module tb_frame_sequencer;

  logic        clock;
  logic        resetn;
  logic [3:0]  keys;
  logic        pause;
  logic        playerDone, obstacleDone, renderDone;
  logic        playerUpdate, obstacleUpdate, renderReq, timeoutFlag, busy;
  logic [3:0]  keysFrame;
  logic [15:0] frameCount;
  logic [7:0]  overruns;

  logic        t_pause, t_player_done, t_obstacle_done, t_render_done;
  logic        t_player_update, t_obstacle_update, t_render_req, t_timeout_flag, t_busy;
  logic [3:0]  t_keys_frame;
  logic [15:0] t_frame_count;
  logic [7:0]  t_overruns;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int r_delay = 1;
  int rr_cnt = 0;
  logic pu_q, ou_q;
  logic saw_strobe;

  frame_sequencer #(.TICK_DIVIDE(10), .TIMEOUT(40)) dut (
    .clock(clock), .resetn(resetn), .keys(keys), .pause(pause),
    .playerDone(playerDone), .obstacleDone(obstacleDone), .renderDone(renderDone),
    .playerUpdate(playerUpdate), .obstacleUpdate(obstacleUpdate), .renderReq(renderReq),
    .keysFrame(keysFrame), .frameCount(frameCount), .overruns(overruns),
    .timeoutFlag(timeoutFlag), .busy(busy)
  );

  frame_sequencer #(.TICK_DIVIDE(10), .TIMEOUT(4)) tdut (
    .clock(clock), .resetn(resetn), .keys(keys), .pause(t_pause),
    .playerDone(t_player_done), .obstacleDone(t_obstacle_done), .renderDone(t_render_done),
    .playerUpdate(t_player_update), .obstacleUpdate(t_obstacle_update), .renderReq(t_render_req),
    .keysFrame(t_keys_frame), .frameCount(t_frame_count), .overruns(t_overruns),
    .timeoutFlag(t_timeout_flag), .busy(t_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Responder: player/obstacle done one cycle after the strobe, renderDone r_delay cycles after renderReq rises.
  initial begin
    playerDone = 1'b0; obstacleDone = 1'b0; renderDone = 1'b0;
    pu_q = 1'b0; ou_q = 1'b0;
    forever begin
      @(negedge clock);
      playerDone   = pu_q;
      pu_q         = playerUpdate;
      obstacleDone = ou_q;
      ou_q         = obstacleUpdate;
      if (renderReq) rr_cnt++;
      else rr_cnt = 0;
      renderDone = renderReq && (rr_cnt == r_delay + 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    resetn = 1'b0; keys = 4'hF; pause = 1'b0;
    t_pause = 1'b0; t_player_done = 1'b0; t_obstacle_done = 1'b0; t_render_done = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_player_update", {31'd0, playerUpdate}, 32'd0);
    check("rst_obstacle_update", {31'd0, obstacleUpdate}, 32'd0);
    check("rst_render_req", {31'd0, renderReq}, 32'd0);
    check("rst_keys_frame", {28'd0, keysFrame}, 32'hF);
    check("rst_frame_count", {16'd0, frameCount}, 32'd0);
    check("rst_overruns", {24'd0, overruns}, 32'd0);
    check("rst_timeout_flag", {31'd0, timeoutFlag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_t_keys_frame", {28'd0, t_keys_frame}, 32'hF);
    check("rst_t_busy", {31'd0, t_busy}, 32'd0);

    resetn = 1'b1; cyc = 0;
    step_to(10); check("first_pu_early", {31'd0, playerUpdate}, 32'd0);
    step_to(11); check("first_pu", {31'd0, playerUpdate}, 32'd1);
    check("first_busy", {31'd0, busy}, 32'd1);
    check("t_first_pu", {31'd0, t_player_update}, 32'd1);
    check("t_flag_clear", {31'd0, t_timeout_flag}, 32'd0);
    step_to(13); check("first_ou", {31'd0, obstacleUpdate}, 32'd1);
    step_to(14); check("t_ou_early", {31'd0, t_obstacle_update}, 32'd0);
    step_to(15); check("first_rr", {31'd0, renderReq}, 32'd1);
    check("t_ou_timeout", {31'd0, t_obstacle_update}, 32'd1);
    check("t_flag_set", {31'd0, t_timeout_flag}, 32'd1);
    step_to(17); check("first_fc", {16'd0, frameCount}, 32'd1);
    check("first_busy_low", {31'd0, busy}, 32'd0);
    step_to(18); check("t_rr_early", {31'd0, t_render_req}, 32'd0);
    step_to(19); check("t_rr_timeout", {31'd0, t_render_req}, 32'd1);
    step_to(23); check("t_fc_1", {16'd0, t_frame_count}, 32'd1);
    step_to(50); check("t_simul_no_overrun", {24'd0, t_overruns}, 32'd0);
    check("t_simul_busy", {31'd0, t_busy}, 32'd1);
    check("t_fc_3", {16'd0, t_frame_count}, 32'd3);
    step_to(57); check("nominal_fc5", {16'd0, frameCount}, 32'd5);
    check("nominal_overruns", {24'd0, overruns}, 32'd0);
    check("nominal_no_timeout", {31'd0, timeoutFlag}, 32'd0);
    step_to(60); check("t_overrun_1", {24'd0, t_overruns}, 32'd1);
    check("t_flag_sticky", {31'd0, t_timeout_flag}, 32'd1);

    r_delay = 25;
    step_to(61); check("slow_pu", {31'd0, playerUpdate}, 32'd1);
    step_to(80); check("slow_overrun1", {24'd0, overruns}, 32'd1);
    step_to(90); check("slow_overrun2", {24'd0, overruns}, 32'd2);
    check("slow_rr_held", {31'd0, renderReq}, 32'd1);
    step_to(91); check("slow_fc6", {16'd0, frameCount}, 32'd6);
    check("slow_busy_low", {31'd0, busy}, 32'd0);
    step_to(92); check("slow_back_to_back", {31'd0, playerUpdate}, 32'd1);
    r_delay = 1;
    step_to(98); check("fc7", {16'd0, frameCount}, 32'd7);

    step_to(102); keys = 4'b1110;
    step_to(106); check("keys_mid_frame", {28'd0, keysFrame}, 32'hF);
    step_to(110); check("keys_before_start", {28'd0, keysFrame}, 32'hF);
    step_to(111); check("keys_latched", {28'd0, keysFrame}, 32'hE);

    step_to(112); pause = 1'b1;
    step_to(117); check("pause_frame_completes", {16'd0, frameCount}, 32'd9);
    saw_strobe = 1'b0;
    while (cyc < 145) begin
      step_to(cyc + 1);
      if (playerUpdate || obstacleUpdate || renderReq) saw_strobe = 1'b1;
    end
    check("pause_no_strobes", {31'd0, saw_strobe}, 32'd0);
    check("pause_overruns", {24'd0, overruns}, 32'd4);
    check("pause_idle", {31'd0, busy}, 32'd0);
    pause = 1'b0;
    step_to(146); check("unpause_pu", {31'd0, playerUpdate}, 32'd1);

    step_to(150); check("pre_reset_rr", {31'd0, renderReq}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rr", {31'd0, renderReq}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_fc", {16'd0, frameCount}, 32'd0);
    check("async_keys", {28'd0, keysFrame}, 32'hF);
    check("async_t_flag", {31'd0, t_timeout_flag}, 32'd0);
    @(negedge clock);
    resetn = 1'b1; cyc = 0;
    step_to(10); check("post_reset_pu_early", {31'd0, playerUpdate}, 32'd0);
    step_to(11); check("post_reset_pu", {31'd0, playerUpdate}, 32'd1);
    step_to(17); check("post_reset_fc", {16'd0, frameCount}, 32'd1);

    pause = 1'b1;
    step_to(3200); check("overrun_saturate", {24'd0, overruns}, 32'hFF);
    check("sat_idle", {31'd0, busy}, 32'd0);
    force dut.frameCount = 16'hFFFF;
    step_to(3201);
    release dut.frameCount;
    step_to(3202); pause = 1'b0;
    step_to(3209); check("fc_wrap", {16'd0, frameCount}, 32'd0);
    check("wrap_busy_low", {31'd0, busy}, 32'd0);
    check("sat_hold", {24'd0, overruns}, 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
